// File: rtl/fnd_mode_display_pkg.sv
// Shared encodings for the FND output path: segment codes, source/view selects
// and BCD split helpers. Used by fnd_mode_display and the button router.
package fnd_mode_display_pkg;

   localparam logic MODE_WATCH     = 1'b0;
   localparam logic MODE_STOPWATCH = 1'b1;

   typedef enum logic {
      VIEW_SECMSEC = 1'b0,
      VIEW_HOURMIN = 1'b1
   } viewT;

   // Active-low {dp,g,f,e,d,c,b,a}; dp is off in every stored code.
   localparam logic [7:0] SEG_DIGIT [10] = '{
      8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
      8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
   };
   localparam logic [7:0] SEG_DASH  = 8'hBF;
   localparam logic [7:0] SEG_BLANK = 8'hFF;

   localparam logic [1:0] SEPARATOR_DIGIT = 2'd2;

   function automatic logic [3:0] tensOf(input logic [6:0] v);
      return 4'(v / 7'd10);
   endfunction

   function automatic logic [3:0] onesOf(input logic [6:0] v);
      return 4'(v % 7'd10);
   endfunction

endpackage

// File: rtl/fnd_mode_display_bcd_decoder.sv
// Combinational digit-to-segment decoder for a common-anode FND.
// Digits above 9 render as a dash; dpOn lights the decimal point.
module fnd_bcd_decoder
   import fnd_mode_display_pkg::*;
(
   input  logic [3:0] digit,
   input  logic       dpOn,
   output logic [7:0] seg
);

   // NOTE: seg gets a default before the case so no path leaves it unassigned,
   // which would otherwise infer a latch.
   always_comb begin
      seg = SEG_DASH;
      case (digit)
         4'd0:    seg = SEG_DIGIT[0];
         4'd1:    seg = SEG_DIGIT[1];
         4'd2:    seg = SEG_DIGIT[2];
         4'd3:    seg = SEG_DIGIT[3];
         4'd4:    seg = SEG_DIGIT[4];
         4'd5:    seg = SEG_DIGIT[5];
         4'd6:    seg = SEG_DIGIT[6];
         4'd7:    seg = SEG_DIGIT[7];
         4'd8:    seg = SEG_DIGIT[8];
         4'd9:    seg = SEG_DIGIT[9];
         default: seg = SEG_DASH;
      endcase
      seg[7] = ~dpOn;
   end

endmodule

// File: rtl/fnd_mode_display.sv
// Selects watch or stopwatch time by mode1, snapshots it once per scan frame
// and multiplexes four BCD digits onto the FND. Optional: FND_BLINK_DP_EN.
module fnd_mode_display
   import fnd_mode_display_pkg::*;
#(
   parameter int CLK_FREQ = 100_000_000,
   parameter int SCAN_HZ  = 1000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       mode1,
   input  logic       view_sel,
   input  logic [6:0] w_msec,
   input  logic [5:0] w_sec,
   input  logic [5:0] w_min,
   input  logic [4:0] w_hour,
   input  logic [6:0] s_msec,
   input  logic [5:0] s_sec,
   input  logic [5:0] s_min,
   input  logic [4:0] s_hour,
   output logic [3:0] fnd_com,
   output logic [7:0] fnd_data
);

   localparam int DIV = CLK_FREQ / SCAN_HZ;
   localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

   logic [CW-1:0] divCnt;
   logic          tick;
   logic          tickD;
   logic [1:0]    idx;
   logic          frameEnd;

   viewT       snapView;
   logic [6:0] snapMsec;
   logic [5:0] snapSec;
   logic [5:0] snapMin;
   logic [4:0] snapHour;

   logic [6:0] hiVal;
   logic [6:0] loVal;
   logic [3:0] digitVal;
   logic       dpOn;
   logic [7:0] segNext;
   logic [3:0] comNext;

   assign tick     = (divCnt == CW'(DIV - 1));
   assign frameEnd = tick && (idx == 2'd3);

   // NOTE: all state uses non-blocking assignments so every register samples
   // pre-edge values and the block order cannot change behaviour.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         divCnt <= '0;
         tickD  <= 1'b0;
         idx    <= 2'd0;
      end else begin
         divCnt <= tick ? '0 : divCnt + 1'b1;
         tickD  <= tick;
         if (tick) idx <= idx + 2'd1;
      end
   end

   // The source choice is folded into the latched fields, so mode1 itself
   // needs no separate register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         snapView <= VIEW_SECMSEC;
         snapMsec <= '0;
         snapSec  <= '0;
         snapMin  <= '0;
         snapHour <= '0;
      end else if (frameEnd) begin
         snapView <= viewT'(view_sel);
         if (mode1 == MODE_STOPWATCH) begin
            snapMsec <= s_msec;
            snapSec  <= s_sec;
            snapMin  <= s_min;
            snapHour <= s_hour;
         end else begin
            snapMsec <= w_msec;
            snapSec  <= w_sec;
            snapMin  <= w_min;
            snapHour <= w_hour;
         end
      end
   end

   always_comb begin
      hiVal    = {1'b0, snapSec};
      loVal    = snapMsec;
      digitVal = 4'd0;
      if (snapView == VIEW_HOURMIN) begin
         hiVal = {2'b00, snapHour};
         loVal = {1'b0, snapMin};
      end
      case (idx)
         2'd0:    digitVal = onesOf(loVal);
         2'd1:    digitVal = tensOf(loVal);
         2'd2:    digitVal = onesOf(hiVal);
         default: digitVal = tensOf(hiVal);
      endcase
`ifdef FND_BLINK_DP_EN
      dpOn = (idx == SEPARATOR_DIGIT) && (snapMsec < 7'd50);
`else
      dpOn = (idx == SEPARATOR_DIGIT);
`endif
      comNext = ~(4'b0001 << idx);
   end

   fnd_bcd_decoder u_decoder (
      .digit (digitVal),
      .dpOn  (dpOn),
      .seg   (segNext)
   );

   // Outputs load one cycle after the tick so they follow the new index.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fnd_com  <= 4'hF;
         fnd_data <= SEG_BLANK;
      end else if (tickD) begin
         fnd_com  <= comNext;
         fnd_data <= segNext;
      end
   end

endmodule

// File: doc/fnd_mode_display.md
Name: fnd_mode_display

Overview:
- Output-side counterpart of the button/mode router: the router steers buttons into the watch or the stopwatch core by `mode1`; this block collects time from both cores, selects one by `mode1`, and drives the 4-digit common-anode FND.
- Snapshots the selected time once per scan frame, splits it into BCD digits and time-multiplexes the digits.
- Sits between the watch/stopwatch datapaths and the board FND pins.

Parameters:
- CLK_FREQ, 100_000_000, input clock frequency in Hz.
- SCAN_HZ, 1000, digit-advance rate in Hz; frame rate = SCAN_HZ/4.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- mode1  in  1  1 = stopwatch source, 0 = watch source; same encoding as the button router.
- view_sel  in  1  0 = show sec:msec, 1 = show hour:min.
- w_msec  in  7  watch centiseconds, 0–99.
- w_sec  in  6  watch seconds, 0–59.
- w_min  in  6  watch minutes, 0–59.
- w_hour  in  5  watch hours, 0–23.
- s_msec  in  7  stopwatch centiseconds.
- s_sec  in  6  stopwatch seconds.
- s_min  in  6  stopwatch minutes.
- s_hour  in  5  stopwatch hours.
- fnd_com  out  4  digit enables, active-low; bit0 = rightmost digit.
- fnd_data  out  8  segments {dp,g,f,e,d,c,b,a}, active-low.

Behaviour:
- Reset (rst=0, asynchronous): fnd_com=4'b1111, fnd_data=8'hFF, divider=0, digit index=0, snapshot registers=0. Outputs stay blank until the first tick after release.
- Divider:
  - Counts 0..CLK_FREQ/SCAN_HZ-1, then wraps to 0.
  - A 1-cycle tick is emitted on the wrap cycle.
- Digit index:
  - 2-bit; advances on each tick: 0→1→2→3→0.
- Snapshot:
  - When a tick moves the index from 3 to 0, latch mode1 and view_sel.
  - On the same tick, latch the four time fields of the source selected by the new mode1.
  - No tearing within a frame. A mode1 or view_sel change takes effect at the next frame boundary (worst-case latency 4 ticks).
- Digit mapping:
  - view_sel=0: digits {3,2,1,0} = {sec/10, sec%10, msec/10, msec%10}.
  - view_sel=1: digits {3,2,1,0} = {hour/10, hour%10, min/10, min%10}.
- Out-of-range values: any digit >9 (e.g. msec=120 gives tens=12) is shown as a dash, 8'hBF.
- Segment codes, digits 0–9: C0, F9, A4, B0, 99, 92, 82, F8, 80, 90.
- Decimal point: lit only on digit 2 (the separator); all other digits have dp=1.
- Output registers:
  - fnd_com and fnd_data are registered; they update on the clock edge following the tick, i.e. 1 cycle latency from index change.
  - fnd_com has exactly one bit low at any time after the first tick.
  - There is no blanking gap between digits.
- Simultaneous events: a mode1 toggle in the same cycle as the frame-boundary tick is captured by that tick.
- Reset mid-frame: everything returns to reset values immediately; no partial frame is held.

Optional Feature:
- Macro: FND_BLINK_DP_EN.
- Defined:
  - Digit 2's dp is lit when the snapshot msec < 50 and off otherwise, giving a 1 Hz blink.
  - Applies in both views; in hour:min view it uses the snapshot source's msec field, which is latched together with the other fields.
- Undefined: digit 2's dp is lit continuously.

Decomposition:
- Shared package:
  - Segment-code constants (digits 0–9, dash, blank).
  - MODE_WATCH=1'b0, MODE_STOPWATCH=1'b1, reused by the button router.
  - VIEW_SECMSEC / VIEW_HOURMIN encodings.
- One natural sub-module: fnd_bcd_decoder, combinational 4-bit digit plus dp in → 8-bit active-low segment pattern out; handles >9 → dash.

Test Plan (CLK_FREQ=1000, SCAN_HZ=100, so a tick every 10 cycles):
- Reset: hold rst=0 for 5 cycles → fnd_com=4'hF and fnd_data=8'hFF throughout; first digit enable appears 11 cycles after release.
- Watch sec:msec: mode1=0, view_sel=0, w_sec=42, w_msec=7 → frame shows digits 4,2,0,7; digit 2 reads 8'h24 (dp lit), digit 0 reads 8'hF8.
- Mode switch mid-frame: toggle mode1 to 1 while index=1 with s_sec=15, s_msec=30 → display stays on watch values until the 3→0 tick, then shows 1,5,3,0.
- Hour:min view: view_sel=1, w_hour=23, w_min=59 → digits 2,3,5,9; digit 3=8'hA4, digit 0=8'h90.
- Out-of-range: w_msec=120 → digit 1 = 8'hBF, digit 0 = 8'hC0.
- FND_BLINK_DP_EN: w_msec=49 → digit 2 dp=0 (lit); w_msec=50 → digit 2 dp=1 (off). With the macro undefined, dp=0 (lit) for both values.
